ym_ch_accum_mix: RTL and testbench

Parametrised channel accumulator and output mixer for the FM core's operator pipeline. It takes one operator output per operator slot in op-major order (`slot = op*CHANNELS + ch`) and sums the carrier contributions of each channel with per-channel storage. The sum saturates or wraps by parameter. Once a channel's last operator has been summed, the block emits that channel's sample together with its index, pan and mute gating. DAC override on a selected channel and a sticky clip flag are also provided.

---
 rtl/ym_ch_accum_mix.sv | 167 ++++++++++++++++
 tb/tb_ym_ch_accum_mix.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ym_ch_accum_mix.sv
// Channel accumulator and output mixer: sums carrier operator outputs per channel in
// op-major slot order, saturating or wrapping, and emits each finished channel with pan/mute/DAC.
module ym_ch_accum_mix #(
    parameter int CHANNELS  = 6,
    parameter int OPS       = 4,
    parameter int IN_WIDTH  = 9,
    parameter int ACC_WIDTH = 9,
    parameter int SAT       = 1,
    parameter int DAC_CH    = 5
) (
    input  logic                        MCLK,
    input  logic                        reset,
    input  logic                        slot_en,
    input  logic                        sync,
    input  logic [IN_WIDTH-1:0]         op_value,
    input  logic                        op_out,
    input  logic                        dac_en,
    input  logic [ACC_WIDTH-1:0]        dac,
    input  logic [1:0]                  pan,
    input  logic [CHANNELS-1:0]         mute,
    input  logic                        clip_clr,
    output logic [ACC_WIDTH-1:0]        ch_out,
    output logic [$clog2(CHANNELS)-1:0] ch_idx,
    output logic [1:0]                  ch_pan,
    output logic                        ch_valid,
    output logic                        clip
);

    localparam int CW = $clog2(CHANNELS);
    localparam int OW = (OPS > 1) ? $clog2(OPS) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
    localparam logic [OW-1:0] OP_LAST = OW'(OPS - 1);
    localparam logic [CW-1:0] DAC_IDX = CW'(DAC_CH);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [CW-1:0]        ch_cnt_r;
    logic [OW-1:0]        op_cnt_r;
    logic [ACC_WIDTH-1:0] acc_r [CHANNELS];

    logic [CW-1:0]        cur_ch_s;
    logic [OW-1:0]        cur_op_s;
    logic [CW-1:0]        nxt_ch_s;
    logic [OW-1:0]        nxt_op_s;
    logic [ACC_WIDTH-1:0] v_s;
    logic [ACC_WIDTH-1:0] acc_cur_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 ovf_s;
    logic [ACC_WIDTH-1:0] res_s;
    logic                 emit_s;
    logic [ACC_WIDTH-1:0] emit_val_s;
    logic [1:0]           emit_pan_s;

    logic [ACC_WIDTH-1:0] ch_out_r;
    logic [CW-1:0]        ch_idx_r;
    logic [1:0]           ch_pan_r;
    logic                 ch_valid_r;
    logic                 clip_r;

    // Current slot decode (sync forces slot 0) and the following counter position.
    always_comb begin
        cur_ch_s = ch_cnt_r;
        cur_op_s = op_cnt_r;
        nxt_ch_s = ch_cnt_r;
        nxt_op_s = op_cnt_r;
        if (sync) begin
            cur_ch_s = {CW{1'b0}};
            cur_op_s = {OW{1'b0}};
        end else begin
            cur_ch_s = ch_cnt_r;
            cur_op_s = op_cnt_r;
        end
        if (cur_ch_s == CH_LAST) begin
            nxt_ch_s = {CW{1'b0}};
            if (cur_op_s == OP_LAST) begin
                nxt_op_s = {OW{1'b0}};
            end else begin
                nxt_op_s = cur_op_s + 1'b1;
            end
        end else begin
            nxt_ch_s = cur_ch_s + 1'b1;
            nxt_op_s = cur_op_s;
        end
    end

    // Contribution, widened sum, overflow detection and clamp/wrap of the slot result.
    always_comb begin
        ovf_s     = 1'b0;
        res_s     = {ACC_WIDTH{1'b0}};
        acc_cur_s = acc_r[cur_ch_s];
        if (op_out) begin
            v_s = ACC_WIDTH'($signed(op_value));
        end else begin
            v_s = {ACC_WIDTH{1'b0}};
        end
        sum_s = {acc_cur_s[ACC_WIDTH-1], acc_cur_s} + {v_s[ACC_WIDTH-1], v_s};
        if (cur_op_s == {OW{1'b0}}) begin
            res_s = v_s;
        end else if (sum_s[ACC_WIDTH] != sum_s[ACC_WIDTH-1]) begin
            ovf_s = 1'b1;
            if (SAT != 0) begin
                res_s = sum_s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                res_s = sum_s[ACC_WIDTH-1:0];
            end
        end else begin
            res_s = sum_s[ACC_WIDTH-1:0];
        end
    end

    // Emitted sample selection: mute beats DAC override beats the accumulated result.
    always_comb begin
        emit_s = (cur_op_s == OP_LAST);
        if (mute[cur_ch_s]) begin
            emit_val_s = {ACC_WIDTH{1'b0}};
            emit_pan_s = 2'b00;
        end else if (dac_en && (cur_ch_s == DAC_IDX)) begin
            emit_val_s = {~dac[ACC_WIDTH-1], dac[ACC_WIDTH-2:0]};
            emit_pan_s = pan;
        end else begin
            emit_val_s = res_s;
            emit_pan_s = pan;
        end
    end

    // Slot counters, per-channel accumulators, registered outputs and sticky clip.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            ch_cnt_r   <= {CW{1'b0}};
            op_cnt_r   <= {OW{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= {ACC_WIDTH{1'b0}};
            end
            ch_out_r   <= {ACC_WIDTH{1'b0}};
            ch_idx_r   <= {CW{1'b0}};
            ch_pan_r   <= 2'b00;
            ch_valid_r <= 1'b0;
            clip_r     <= 1'b0;
        end else begin
            ch_valid_r <= 1'b0;
            if (slot_en) begin
                ch_cnt_r        <= nxt_ch_s;
                op_cnt_r        <= nxt_op_s;
                acc_r[cur_ch_s] <= res_s;
                if (emit_s) begin
                    ch_out_r   <= emit_val_s;
                    ch_idx_r   <= cur_ch_s;
                    ch_pan_r   <= emit_pan_s;
                    ch_valid_r <= 1'b1;
                end
            end
            // A new overflow outranks a simultaneous clear.
            if (slot_en && ovf_s) begin
                clip_r <= 1'b1;
            end else if (clip_clr) begin
                clip_r <= 1'b0;
            end
        end
    end

    assign ch_out   = ch_out_r;
    assign ch_idx   = ch_idx_r;
    assign ch_pan   = ch_pan_r;
    assign ch_valid = ch_valid_r;
    assign clip     = clip_r;

endmodule

// File: tb/tb_ym_ch_accum_mix.sv
// Bench for ym_ch_accum_mix: a saturating and a wrapping instance share stimulus and are
// compared every slot against a plain-integer frame model.
module tb_ym_ch_accum_mix;

    localparam int NCH  = 6;
    localparam int NOPS = 4;

    logic       clk = 1'b0;
    logic       reset, slot_en, sync, op_out, dac_en, clip_clr;
    logic [8:0] op_value, dac;
    logic [1:0] pan;
    logic [5:0] mute;

    logic [8:0] o_out   [2];
    logic [2:0] o_idx   [2];
    logic [1:0] o_pan   [2];
    logic       o_valid [2];
    logic       o_clip  [2];

    int m_ch, m_op;
    int m_acc   [2][NCH];
    int e_out   [2];
    int e_idx   [2];
    int e_pan   [2];
    int e_valid [2];
    int e_clip  [2];
    int n_pass = 0, n_fail = 0, n_total = 0;

    always #5 clk = ~clk;

    ym_ch_accum_mix #(.SAT(1)) dut_sat (
        .MCLK(clk), .reset(reset), .slot_en(slot_en), .sync(sync), .op_value(op_value),
        .op_out(op_out), .dac_en(dac_en), .dac(dac), .pan(pan), .mute(mute), .clip_clr(clip_clr),
        .ch_out(o_out[0]), .ch_idx(o_idx[0]), .ch_pan(o_pan[0]), .ch_valid(o_valid[0]), .clip(o_clip[0])
    );

    ym_ch_accum_mix #(.SAT(0)) dut_wrap (
        .MCLK(clk), .reset(reset), .slot_en(slot_en), .sync(sync), .op_value(op_value),
        .op_out(op_out), .dac_en(dac_en), .dac(dac), .pan(pan), .mute(mute), .clip_clr(clip_clr),
        .ch_out(o_out[1]), .ch_idx(o_idx[1]), .ch_pan(o_pan[1]), .ch_valid(o_valid[1]), .clip(o_clip[1])
    );

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[dut%0d]: got %0d, want %0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("ch_valid", k, int'(o_valid[k]), e_valid[k]);
            chk("ch_out",   k, int'($signed(o_out[k])), e_out[k]);
            chk("ch_idx",   k, int'(o_idx[k]), e_idx[k]);
            chk("ch_pan",   k, int'(o_pan[k]), e_pan[k]);
            chk("clip",     k, int'(o_clip[k]), e_clip[k]);
        end
    endtask

    task automatic model_reset();
        m_ch = 0;
        m_op = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NCH; c++) m_acc[k][c] = 0;
            e_out[k] = 0; e_idx[k] = 0; e_pan[k] = 0; e_valid[k] = 0; e_clip[k] = 0;
        end
    endtask

    // One slot of the reference: load on op 0, add with clamp or wrap otherwise, emit on the last op.
    task automatic model_slot(input bit en, input bit sy, input int val, input bit oo,
                              input logic [1:0] p, input logic [5:0] mu, input bit de,
                              input logic [8:0] d, input bit cc);
        int ch, op, v, s, r;
        bit ovf;
        ch = sy ? 0 : m_ch;
        op = sy ? 0 : m_op;
        v  = oo ? val : 0;
        for (int k = 0; k < 2; k++) begin
            ovf = 1'b0;
            e_valid[k] = 0;
            if (en) begin
                if (op == 0) begin
                    r = v;
                end else begin
                    s = m_acc[k][ch] + v;
                    r = s;
                    if (s > 255 || s < -256) begin
                        ovf = 1'b1;
                        if (k == 0) r = (s > 255) ? 255 : -256;
                        else        r = (s > 255) ? s - 512 : s + 512;
                    end
                end
                m_acc[k][ch] = r;
                if (op == NOPS - 1) begin
                    e_valid[k] = 1;
                    e_idx[k]   = ch;
                    if (mu[ch]) begin
                        e_out[k] = 0;
                        e_pan[k] = 0;
                    end else begin
                        e_out[k] = (de && ch == 5) ? int'(d) - 256 : r;
                        e_pan[k] = int'(p);
                    end
                end
            end
            if (ovf) e_clip[k] = 1;
            else if (cc) e_clip[k] = 0;
        end
        if (en) begin
            m_ch = ch + 1;
            m_op = op;
            if (m_ch == NCH) begin
                m_ch = 0;
                m_op = (op + 1) % NOPS;
            end
        end
    endtask

    task automatic step(input bit en, input bit sy, input int val, input bit oo,
                        input logic [1:0] p, input logic [5:0] mu, input bit de,
                        input logic [8:0] d, input bit cc);
        @(negedge clk);
        reset = 1'b0; slot_en = en; sync = sy; op_value = 9'(val); op_out = oo;
        pan = p; mute = mu; dac_en = de; dac = d; clip_clr = cc;
        model_slot(en, sy, val, oo, p, mu, de, d, cc);
        @(posedge clk);
        #1 check_all();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1; slot_en = 1'($urandom); sync = 1'($urandom); op_value = 9'($urandom);
            op_out = 1'($urandom); pan = 2'($urandom); mute = 6'($urandom); dac_en = 1'($urandom);
            dac = 9'($urandom); clip_clr = 1'($urandom);
            @(posedge clk);
        end
        model_reset();
        #1 check_all();
    endtask

    task automatic rand_slot(input bit en, input bit sy);
        step(en, sy, int'($urandom_range(0, 511)) - 256, 1'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0, 1'($urandom), 9'($urandom),
             $urandom_range(0, 7) == 0);
    endtask

    // Directed frames: kind selects the scenario, unlisted channels carry zero.
    task automatic dframe(input int kind);
        int ch, op, val;
        bit oo, de, cc;
        logic [5:0] mu;
        logic [8:0] d;
        for (int s = 0; s < NCH * NOPS; s++) begin
            ch = s % NCH; op = s / NCH;
            val = 0; oo = 1'b1; de = 1'b0; cc = 1'b0; mu = 6'b0; d = 9'h000;
            case (kind)
                0: begin
                    if (ch == 0) val = 10 * (op + 1);
                    if (ch == 1 && op < 2) val = 255;
                end
                1: begin
                    if (ch == 0) begin val = 10 * (op + 1); oo = !(op == 1 || op == 2); end
                    if (ch == 1 && op < 2) val = -256;
                    cc = (s == 0) || (s == 7);
                end
                2: begin
                    if (ch == 2) val = (op == 0) ? 255 : (op == 1) ? 1 : 0;
                    de = 1'b1; d = 9'h000;
                end
                3: begin
                    if (ch == 5) val = 77;
                    de = 1'b1; d = 9'h1FF;
                end
                default: begin
                    if (ch == 5 || ch == 3) val = -100;
                    de = 1'b1; d = 9'h1FF; mu = 6'b101000;
                end
            endcase
            step(1'b1, 1'b0, val, oo, 2'((ch + op) % 4), mu, de, d, cc);
        end
    endtask

    initial begin
        model_reset();
        do_reset(3);
        for (int f = 0; f < 5; f++) dframe(f);
        step(1'b0, 1'b0, 0, 1'b0, 2'b00, 6'b0, 1'b0, 9'h000, 1'b0);
        for (int i = 0; i < 90; i++) rand_slot($urandom_range(0, 3) != 0, 1'b0);
        // Sync mid-frame at slot 9, then enough slots to reach the next emit on channel 0.
        do_reset(1);
        for (int i = 0; i < 9; i++) rand_slot(1'b1, 1'b0);
        rand_slot(1'b1, 1'b1);
        for (int i = 0; i < 24; i++) rand_slot(1'b1, 1'b0);
        // Reset mid-frame discards partial sums and restarts at slot 0.
        for (int i = 0; i < 5; i++) rand_slot(1'b1, 1'b0);
        do_reset(1);
        for (int i = 0; i < 26; i++) rand_slot(1'b1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
